// File: rtl/mem_tst_pkg.sv
// Shared types and constants for the memory write initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_tst_pkg;

    // Word width of the tester memory write port; the memory block uses the same value.
    localparam int MEM_DATA_W = 6;

    // Number of WAIT_ACK cycles allowed before a write is abandoned.
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

endpackage

// File: rtl/mem_wr_master_if.sv
// Bundle of sequencer, memory and status signals around the write initiator.
// Latency: n/a (wiring only).
// Backpressure: out_ready gates in_valid; the memory answers through in_mem_wrt_rd.
// Ports (master view = initiator):
//   in_data/in_valid -> out_ready          sequencer word push
//   out_mem/out_mem_wrt_en -> in_mem/in_mem_wrt_rd   memory write and echo
//   in_clr_err, out_busy, out_done, out_err_cnt, out_timeout   status
interface mem_wr_master_if #(
    parameter int DATA_W = mem_tst_pkg::MEM_DATA_W,
    parameter int ERR_W  = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_mem;
    logic              out_mem_wrt_en;
    logic [DATA_W-1:0] in_mem;
    logic              in_mem_wrt_rd;
    logic              in_clr_err;
    logic              out_busy;
    logic              out_done;
    logic [ERR_W-1:0]  out_err_cnt;
    logic              out_timeout;

    modport master (
        input  in_data, in_valid, in_mem, in_mem_wrt_rd, in_clr_err,
        output out_ready, out_mem, out_mem_wrt_en, out_busy, out_done,
               out_err_cnt, out_timeout
    );

    modport slave (
        output in_data, in_valid, in_mem, in_mem_wrt_rd, in_clr_err,
        input  out_ready, out_mem, out_mem_wrt_en, out_busy, out_done,
               out_err_cnt, out_timeout
    );
endinterface

// File: rtl/mem_tst_fifo.sv
// Synchronous FIFO holding pattern words between the sequencer and the write FSM.
// Latency: a pushed word is poppable the cycle after the push edge; pop data is combinational from the head.
// Backpressure: pushes while full are dropped (caller must gate on !full_o); pops while empty are ignored.
// Ports: clk/rst_n, push_i/push_dat_i, pop_i/pop_dat_o, full_o, empty_o, count_o.
module mem_tst_fifo #(
    parameter int  DATA_W = 6,
    parameter int  DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CNT_W  = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_dat_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is refused even when a pop frees a slot in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_wr_master.sv
// Write initiator: buffers sequencer words, issues one memory write per word, checks the echo.
// Latency: push at edge k -> write enable during k+1..k+2 -> done/error visible after k+3 (ack one cycle late).
// Backpressure: out_ready drops when the FIFO is full; a missing ack is abandoned after TIMEOUT cycles.
// Ports: in_clk, in_rst_n (async active-low), bus (mem_wr_master_if.master).
module mem_wr_master
    import mem_tst_pkg::*;
#(
    parameter int DATA_W  = MEM_DATA_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int ERR_W   = 8
) (
    input  logic            in_clk,
    input  logic            in_rst_n,
    mem_wr_master_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] mem_q;       // doubles as the hold register for the echo compare
    logic [DATA_W-1:0] mem_d;
    logic              wrt_en_q;
    logic              wrt_en_d;
    logic              done_q;
    logic              done_d;
    logic              busy_q;
    logic              busy_d;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_d;
    logic [ERR_W-1:0]  err_q;
    logic [ERR_W-1:0]  err_d;
    logic              timeout_q;
    logic              timeout_d;
    logic              err_inc;
    logic              tmo_hit;

    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_dat;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;

    mem_tst_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (in_clk),
        .rst_n      (in_rst_n),
        .push_i     (bus.in_valid),
        .push_dat_i (bus.in_data),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    assign bus.out_ready      = !fifo_full;
    assign bus.out_mem        = mem_q;
    assign bus.out_mem_wrt_en = wrt_en_q;
    assign bus.out_done       = done_q;
    assign bus.out_busy       = busy_q;
    assign bus.out_err_cnt    = err_q;
    assign bus.out_timeout    = timeout_q;

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wrt_en_d  = 1'b0;
        done_d    = 1'b0;
        tmo_cnt_d = tmo_cnt_q;
        fifo_pop  = 1'b0;
        err_inc   = 1'b0;
        tmo_hit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The enable register is loaded here so it is high exactly while in ISSUE.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mem_d    = fifo_dat;
                    wrt_en_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (bus.in_mem_wrt_rd) begin
                    err_inc = (bus.in_mem != mem_q);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    // Abandon the write; the word is not retried.
                    tmo_hit = 1'b1;
                    err_inc = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status. A clear wins over an increment or a timeout landing in the same cycle.
    always_comb begin
        err_d     = err_q;
        timeout_d = timeout_q;
        if (bus.in_clr_err) begin
            err_d     = '0;
            timeout_d = 1'b0;
        end else begin
            if (err_inc && (err_q != {ERR_W{1'b1}})) begin
                err_d = err_q + ERR_W'(1);
            end
            if (tmo_hit) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Busy is a registered view of the current state and occupancy, so it drops
    // the cycle after the final done once nothing is left queued.
    assign busy_d = (state_q != ST_IDLE) || (fifo_cnt != '0);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= ST_IDLE;
            mem_q     <= '0;
            wrt_en_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            tmo_cnt_q <= '0;
            err_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wrt_en_q  <= wrt_en_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_mem_wr_master.sv
// Bench for mem_wr_master: model memory echoing one cycle late, word scoreboard, status model.
// A second instance with a 2-bit error counter runs in lockstep for the saturation case.
// All DUT outputs are sampled on the falling edge.
module tb_mem_wr_master;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] tb_data;
    logic       tb_valid;
    logic       tb_clr;
    bit         ack_en      = 1'b1;
    bit         late_ack    = 1'b0;
    bit         corrupt_en  = 1'b0;
    bit         corrupt_all = 1'b0;
    logic [5:0] corrupt_word = 6'h00;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_done = 0;

    logic [5:0] exp_q [$];
    int         done_cyc_q [$];
    int         exp_err = 0;
    bit         exp_tmo = 1'b0;
    bit         clr_at_edge = 1'b0;
    bit         cur_ack = 1'b1;
    bit         cur_bad = 1'b0;
    int         wr_cyc = 0;

    always #5 clk = ~clk;

    mem_wr_master_if #(.DATA_W(6), .ERR_W(8)) bus8 ();
    mem_wr_master_if #(.DATA_W(6), .ERR_W(2)) bus2 ();

    assign bus8.in_data    = tb_data;
    assign bus8.in_valid   = tb_valid;
    assign bus8.in_clr_err = tb_clr;
    assign bus2.in_data    = tb_data;
    assign bus2.in_valid   = tb_valid;
    assign bus2.in_clr_err = tb_clr;

    mem_wr_master #(.DATA_W(6), .DEPTH(4), .TIMEOUT(TMO), .ERR_W(8)) dut8 (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus8)
    );

    mem_wr_master #(.DATA_W(6), .DEPTH(4), .TIMEOUT(TMO), .ERR_W(2)) dut2 (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus2)
    );

    function automatic logic [5:0] echo(input logic [5:0] w);
        return (corrupt_all || (corrupt_en && w == corrupt_word)) ? (w ^ 6'h01) : w;
    endfunction

    // Model memories: sample the enable, answer one edge later with the echo.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus8.in_mem_wrt_rd <= 1'b0;
            bus8.in_mem        <= 6'h00;
        end else begin
            bus8.in_mem_wrt_rd <= (ack_en && bus8.out_mem_wrt_en) || late_ack;
            if (bus8.out_mem_wrt_en) bus8.in_mem <= echo(bus8.out_mem);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus2.in_mem_wrt_rd <= 1'b0;
            bus2.in_mem        <= 6'h00;
        end else begin
            bus2.in_mem_wrt_rd <= (ack_en && bus2.out_mem_wrt_en) || late_ack;
            if (bus2.out_mem_wrt_en) bus2.in_mem <= echo(bus2.out_mem);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        clr_at_edge = tb_clr;
    end

    // Scoreboard and status model for the 8-bit instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (clr_at_edge) begin
                exp_err = 0;
                exp_tmo = 1'b0;
            end
            if (bus8.out_mem_wrt_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(1), 32'(0));
                end else begin
                    logic [5:0] w;
                    w = exp_q.pop_front();
                    check("wr_data", 32'(bus8.out_mem), 32'(w));
                    cur_ack = ack_en;
                    cur_bad = corrupt_all || (corrupt_en && w == corrupt_word);
                    wr_cyc  = cyc;
                end
            end
            if (bus8.out_done) begin
                n_done++;
                done_cyc_q.push_back(cyc);
                check("done_latency", 32'(cyc - wr_cyc), cur_ack ? 32'(2) : 32'(TMO + 1));
                if (!clr_at_edge && (!cur_ack || cur_bad) && exp_err < 255) exp_err++;
                if (!clr_at_edge && !cur_ack) exp_tmo = 1'b1;
                check("err_cnt", 32'(bus8.out_err_cnt), 32'(exp_err));
                check("timeout_flag", 32'(bus8.out_timeout), 32'(exp_tmo));
            end
        end
    end

    task automatic push(input logic [5:0] w, input bit accept);
        tb_valid = 1'b1;
        tb_data  = w;
        check("ready", 32'(bus8.out_ready), 32'(accept));
        if (accept) exp_q.push_back(w);
        @(negedge clk);
        tb_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus8.out_done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("done_seen", 32'(0), 32'(1));
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while ((bus8.out_busy || exp_q.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (i >= budget) check("idle_seen", 32'(0), 32'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem"},    32'(bus8.out_mem),        32'(0));
        check({tag, "_wrt_en"}, 32'(bus8.out_mem_wrt_en), 32'(0));
        check({tag, "_done"},   32'(bus8.out_done),       32'(0));
        check({tag, "_err"},    32'(bus8.out_err_cnt),    32'(0));
        check({tag, "_tmo"},    32'(bus8.out_timeout),    32'(0));
        check({tag, "_busy"},   32'(bus8.out_busy),       32'(0));
        check({tag, "_ready"},  32'(bus8.out_ready),      32'(1));
    endtask

    initial begin
        int at;
        int push_cyc;
        int wr_at;
        int done_before;

        rst_n    = 1'b0;
        tb_valid = 1'b0;
        tb_data  = 6'h00;
        tb_clr   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Single write, clean echo.
        push(6'h2A, 1'b1);
        push_cyc = cyc;
        wait_done(10, at);
        check("t1_latency", 32'(at - push_cyc), 32'(3));
        check("t1_busy_in_done", 32'(bus8.out_busy), 32'(1));
        @(negedge clk);
        check("t1_busy_after", 32'(bus8.out_busy), 32'(0));
        check("t1_hold_mem", 32'(bus8.out_mem), 32'(6'h2A));
        check("t1_err", 32'(bus8.out_err_cnt), 32'(0));

        // Stall on an unanswered write so four queued words fill the FIFO.
        done_cyc_q.delete();
        ack_en = 1'b0;
        push(6'h01, 1'b1);
        @(negedge clk);
        @(negedge clk);
        ack_en = 1'b1;
        push(6'h00, 1'b1);
        push(6'h3F, 1'b1);
        push(6'h15, 1'b1);
        push(6'h2A, 1'b1);
        push(6'h07, 1'b0);
        wait_idle(100);
        check("t2_done_count", 32'(done_cyc_q.size()), 32'(5));
        if (done_cyc_q.size() == 5) begin
            for (int i = 2; i < 5; i++)
                check("t2_spacing", 32'(done_cyc_q[i] - done_cyc_q[i-1]), 32'(3));
        end
        check("t2_err", 32'(bus8.out_err_cnt), 32'(1));
        check("t2_tmo", 32'(bus8.out_timeout), 32'(1));

        // Standalone clear, then one corrupted echo among four words.
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
        check("t3_clr_err", 32'(bus8.out_err_cnt), 32'(0));
        check("t3_clr_tmo", 32'(bus8.out_timeout), 32'(0));
        corrupt_en   = 1'b1;
        corrupt_word = 6'h15;
        push(6'h00, 1'b1);
        push(6'h3F, 1'b1);
        push(6'h15, 1'b1);
        push(6'h2A, 1'b1);
        wait_idle(100);
        check("t3_err", 32'(bus8.out_err_cnt), 32'(1));
        corrupt_en = 1'b0;

        // Clear asserted on the very edge a second timeout lands.
        ack_en = 1'b0;
        push(6'h33, 1'b1);
        wr_at = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus8.out_mem_wrt_en) begin
                wr_at = cyc;
                break;
            end
        end
        check("t4_wr_seen", 32'(wr_at >= 0), 32'(1));
        repeat (15) @(negedge clk);
        tb_clr = 1'b1;
        @(negedge clk);
        tb_clr = 1'b0;
        check("t4_done", 32'(bus8.out_done), 32'(1));
        check("t4_err", 32'(bus8.out_err_cnt), 32'(0));
        check("t4_tmo", 32'(bus8.out_timeout), 32'(0));
        ack_en = 1'b1;
        wait_idle(50);

        // Five mismatches: 8-bit counter counts, 2-bit counter sticks at 3.
        corrupt_all = 1'b1;
        for (int i = 1; i <= 5; i++) push(6'(i), 1'b1);
        wait_idle(100);
        check("t5_err8", 32'(bus8.out_err_cnt), 32'(5));
        check("t5_err2_sat", 32'(bus2.out_err_cnt), 32'(3));
        corrupt_all = 1'b0;

        // Reset mid-write with two words still queued.
        ack_en = 1'b0;
        push(6'h0A, 1'b1);
        push(6'h0B, 1'b1);
        push(6'h0C, 1'b1);
        @(negedge clk);
        check("t6_busy_before", 32'(bus8.out_busy), 32'(1));
        done_before = n_done;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6");
        exp_q.delete();
        exp_err = 0;
        exp_tmo = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_no_done", 32'(n_done - done_before), 32'(0));
        check("t6_err", 32'(bus8.out_err_cnt), 32'(0));
        check("t6_busy", 32'(bus8.out_busy), 32'(0));
        check("t6_mem", 32'(bus8.out_mem), 32'(0));
        check("t6_ready", 32'(bus8.out_ready), 32'(1));
        check("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
